// File: rtl/sprite_pos_scheduler.sv
// Sprite position/enable table with a shadow copy that is committed to the active
// table one slot per cycle at vblank, so renderers never see mid-frame changes.
module sprite_pos_scheduler #(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_start,
  input  logic                     i_upd_valid,
  output logic                     o_upd_ready,
  input  logic [IDX_W-1:0]         i_upd_idx,
  input  logic [9:0]               i_upd_x,
  input  logic [9:0]               i_upd_y,
  input  logic                     i_upd_en,
  output logic [10*NUM_SPRITES-1:0] o_sprite_x,
  output logic [10*NUM_SPRITES-1:0] o_sprite_y,
  output logic [NUM_SPRITES-1:0]   o_sprite_en,
  output logic [IDX_W:0]           o_pend_count,
  output logic                     o_commit_done
);

  localparam logic [9:0]       XMax    = 10'(SCREEN_W - 16);
  localparam logic [9:0]       YMax    = 10'(SCREEN_H - 16);
  localparam logic [IDX_W-1:0] LastPtr = IDX_W'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {StAccept, StCommit, StDone} state_e;

  state_e                 r_state;
  logic [IDX_W-1:0]       r_ptr;
  logic                   r_upd_ready;
  logic                   r_commit_done;
  logic [IDX_W:0]         r_pend_count;
  logic [NUM_SPRITES-1:0] r_dirty;
  logic [9:0]             r_shd_x [NUM_SPRITES];
  logic [9:0]             r_shd_y [NUM_SPRITES];
  logic                   r_shd_en[NUM_SPRITES];
  logic [9:0]             r_act_x [NUM_SPRITES];
  logic [9:0]             r_act_y [NUM_SPRITES];
  logic                   r_act_en[NUM_SPRITES];

  logic                   w_hs;
  logic                   w_idx_ok;
  logic                   w_write;
  logic [9:0]             w_x_clamped;
  logic [9:0]             w_y_clamped;
  logic [NUM_SPRITES-1:0] w_dirty_d;
  logic [IDX_W:0]         w_pend_d;

  assign w_hs        = (r_state == StAccept) && i_upd_valid && r_upd_ready;
  assign w_idx_ok    = {1'b0, i_upd_idx} < (IDX_W + 1)'(NUM_SPRITES);
  assign w_write     = w_hs && w_idx_ok;
  assign w_x_clamped = (i_upd_x > XMax) ? XMax : i_upd_x;
  assign w_y_clamped = (i_upd_y > YMax) ? YMax : i_upd_y;

  // pend_count tracks the population of the next dirty mask so it is exact each cycle
  always_comb begin
    w_dirty_d = r_dirty;
    if (w_write) begin
      w_dirty_d[i_upd_idx] = 1'b1;
    end
    if (r_state == StCommit) begin
      w_dirty_d[r_ptr] = 1'b0;
    end
    w_pend_d = '0;
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      w_pend_d = w_pend_d + (IDX_W + 1)'(w_dirty_d[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StAccept;
      r_ptr         <= '0;
      r_upd_ready   <= 1'b0;
      r_commit_done <= 1'b0;
      r_pend_count  <= '0;
      r_dirty       <= '0;
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        r_shd_x[i]  <= '0;
        r_shd_y[i]  <= '0;
        r_shd_en[i] <= 1'b0;
        r_act_x[i]  <= '0;
        r_act_y[i]  <= '0;
        r_act_en[i] <= 1'b0;
      end
    end else begin
      r_dirty       <= w_dirty_d;
      r_pend_count  <= w_pend_d;
      r_commit_done <= 1'b0;
      case (r_state)
        StAccept: begin
          r_upd_ready <= 1'b1;
          if (w_write) begin
            r_shd_x[i_upd_idx]  <= w_x_clamped;
            r_shd_y[i_upd_idx]  <= w_y_clamped;
            r_shd_en[i_upd_idx] <= i_upd_en;
          end
          if (i_frame_start) begin
            r_state     <= StCommit;
            r_ptr       <= '0;
            r_upd_ready <= 1'b0;
          end
        end
        StCommit: begin
          if (r_dirty[r_ptr]) begin
            r_act_x[r_ptr]  <= r_shd_x[r_ptr];
            r_act_y[r_ptr]  <= r_shd_y[r_ptr];
            r_act_en[r_ptr] <= r_shd_en[r_ptr];
          end
          if (r_ptr == LastPtr) begin
            r_state       <= StDone;
            r_commit_done <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        StDone: begin
          r_state     <= StAccept;
          r_upd_ready <= 1'b1;
        end
        default: begin
          r_state     <= StAccept;
          r_upd_ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_sprite_x  = '0;
    o_sprite_y  = '0;
    o_sprite_en = '0;
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      o_sprite_x[10*i +: 10] = r_act_x[i];
      o_sprite_y[10*i +: 10] = r_act_y[i];
      o_sprite_en[i]         = r_act_en[i];
    end
  end

  assign o_upd_ready   = r_upd_ready;
  assign o_commit_done = r_commit_done;
  assign o_pend_count  = r_pend_count;

endmodule
